// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, with quotient and remainder.
// Uses the same start/done handshake as the Booth multiplier so one controller can drive both.
module seq_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dreg_q, dreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             short_q, short_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH+1:0] prem_sh;
    logic [WIDTH+1:0] trial;

    assign dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign prem_sh = {prem_q, dreg_q[WIDTH-1]};
    assign trial   = prem_sh - {2'b00, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dreg_d    = dreg_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        short_d   = short_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neg_quo_d = dvd_neg ^ dvs_neg;
                    neg_rem_d = dvd_neg;
                    // Negating MIN yields MIN, which is already its unsigned magnitude.
                    dreg_d    = dvd_neg ? -dividend_i : dividend_i;
                    dvs_d     = dvs_neg ? -divisor_i : divisor_i;
                    prem_d    = '0;
                    cnt_d     = CNTW'(WIDTH);
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    short_d   = 1'b0;
                    state_d   = StIter;
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        short_d = 1'b1;
                        state_d = StFix;
                    end else if (signed_i && dividend_i == MinVal && divisor_i == '1) begin
                        quo_d   = MinVal;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        short_d = 1'b1;
                        state_d = StFix;
                    end
                end
            end
            StIter: begin
                if (!trial[WIDTH+1]) begin
                    prem_d = trial[WIDTH:0];
                end else begin
                    prem_d = prem_sh[WIDTH:0];
                end
                dreg_d = {dreg_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d  = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Shortcut results were already written on the accepting edge.
                if (!short_q) begin
                    quo_d = neg_quo_q ? -dreg_q : dreg_q;
                    rem_d = neg_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prem_q    <= '0;
            dreg_q    <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            short_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dreg_q    <= dreg_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            short_q   <= short_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

endmodule
